dmem_access_ctrl: RTL and testbench

Sequences data-memory accesses for the instruction held in the EX/MEM pipeline register. It drives a request/acknowledge handshake to a variable-latency data memory and stalls the front of the pipeline while an access is pending. While stalled it inserts bubbles into MEM/WB, and it flushes the younger stages when EX/MEM holds a taken branch. It sits between the EX/MEM register, the data memory port and the MEM/WB register.

---
 rtl/rv_pipe_pkg.sv | 14 +
 rtl/dmem_access_ctrl.sv | 124 ++++++++++++
 tb/tb_dmem_access_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions for the data-memory access controller.
//   dmem_state_t    : access sequencer states
//   WORD_ALIGN_MASK : low address bits that must be zero for a word access
package rv_pipe_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } dmem_state_t;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer for the EX/MEM instruction.
// Issues a registered req/ack transaction to a variable-latency data memory,
// stalls the front of the pipeline while it is pending, bubbles MEM/WB while
// stalled and flushes the younger stages on a taken branch.
//
// state  | meaning
// IDLE   | no access pending; a mem op in EX/MEM starts one
// ACCESS | dmem_req high, waiting for ack or timeout
// DONE   | result (or abort) settled; one unstalled cycle, then IDLE
//
// Ports:
//   clk, reset (async, active low)
//   exmem_mem_read/_write/_branch_taken, exmem_addr, exmem_wdata : EX/MEM inputs
//   dmem_req/_we/_addr/_wdata (out), dmem_ack/_rdata (in)         : memory port
//   load_data                                                      : to MEM/WB
//   stall, bubble, flush                                           : pipeline control
//   err_misaligned (pulse), err_timeout (sticky)                   : status
module dmem_access_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exmem_mem_read,
  input  logic        exmem_mem_write,
  input  logic        exmem_branch_taken,
  input  logic [31:0] exmem_addr,
  input  logic [31:0] exmem_wdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        bubble,
  output logic        flush,
  output logic        err_misaligned,
  output logic        err_timeout
);
  import rv_pipe_pkg::*;

  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  dmem_state_t   state, state_nx;
  logic [CW-1:0] cnt;
  logic          mem_op, misaligned;
  logic          start, mis_go, ack_done, tmo;

  assign mem_op     = exmem_mem_read | exmem_mem_write;
  assign misaligned = |(exmem_addr[1:0] & WORD_ALIGN_MASK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    mis_go   = 1'b0;
    ack_done = 1'b0;
    tmo      = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          if (misaligned) begin
            state_nx = DONE;
            mis_go   = 1'b1;
          end else begin
            state_nx = ACCESS;
            start    = 1'b1;
          end
        end
      end
      ACCESS: begin
        // ack has priority over the terminal count
        if (dmem_ack) begin
          state_nx = DONE;
          ack_done = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nx = DONE;
          tmo      = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      load_data      <= '0;
      err_misaligned <= 1'b0;
      err_timeout    <= 1'b0;
      cnt            <= '0;
    end else begin
      err_misaligned <= mis_go;
      // store wins when both read and write are flagged
      if (start) begin
        dmem_req   <= 1'b1;
        dmem_we    <= exmem_mem_write;
        dmem_addr  <= exmem_addr;
        dmem_wdata <= exmem_wdata;
      end
      if (ack_done || tmo) dmem_req <= 1'b0;
      if (ack_done && !dmem_we) load_data <= dmem_rdata;
      if (tmo || mis_go) load_data <= '0;
      if (tmo) err_timeout <= 1'b1;
      if (state == ACCESS) cnt <= cnt + CW'(1);
      else                 cnt <= '0;
    end
  end

  assign stall  = ((state == IDLE) && mem_op) || (state == ACCESS);
  assign bubble = stall;
  assign flush  = exmem_branch_taken & ~stall;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

  localparam int TMO = 4;

  logic        clk;
  logic        reset;
  logic        exmem_mem_read, exmem_mem_write, exmem_branch_taken;
  logic [31:0] exmem_addr, exmem_wdata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] load_data;
  logic        stall, bubble, flush, err_misaligned, err_timeout;

  int checks   = 0;
  int failures = 0;

  // transaction-level model state
  logic [31:0] exp_load;
  logic        exp_terr;

  dmem_access_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .exmem_mem_read(exmem_mem_read), .exmem_mem_write(exmem_mem_write),
    .exmem_branch_taken(exmem_branch_taken),
    .exmem_addr(exmem_addr), .exmem_wdata(exmem_wdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .load_data(load_data), .stall(stall), .bubble(bubble), .flush(flush),
    .err_misaligned(err_misaligned), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Runs one EX/MEM instruction; entered and left at posedge+1 with DUT idle.
  // lat: cycle of ACCESS in which ack is given (0 = never).
  task automatic run_op(input logic rd, input logic wr, input logic br,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int lat);
    logic mem_op, mis, tmo;
    int   slen, rlen, reqn;
    mem_op = rd | wr;
    mis    = mem_op && (addr[1:0] != 2'b00);
    tmo    = 1'b0;
    if (!mem_op) begin
      slen = 0; rlen = 0;
    end else if (mis) begin
      slen = 1; rlen = 0;
    end else if (lat >= 1 && lat <= TMO) begin
      slen = lat + 1; rlen = lat;
    end else begin
      slen = TMO + 1; rlen = TMO; tmo = 1'b1;
    end
    exmem_mem_read     = rd;
    exmem_mem_write    = wr;
    exmem_branch_taken = br;
    exmem_addr         = addr;
    exmem_wdata        = wdata;
    reqn = 0;
    for (int k = 0; k <= slen; k++) begin
      if (dmem_req) reqn++;
      dmem_ack   = dmem_req && (reqn == lat);
      dmem_rdata = rdata;
      @(negedge clk);
      chk("stall",  32'(stall),  32'(k < slen));
      chk("bubble", 32'(bubble), 32'(k < slen));
      chk("flush",  32'(flush),  32'(br && (k >= slen)));
      chk("req",    32'(dmem_req), 32'((k >= 1) && (k <= rlen)));
      if (dmem_req) begin
        chk("req_addr",  dmem_addr,  addr);
        chk("req_wdata", dmem_wdata, wdata);
        chk("req_we",    32'(dmem_we), 32'(wr));
      end
      chk("err_mis", 32'(err_misaligned), 32'(mis && (k == slen)));
      if (k == slen) begin
        if (mem_op) begin
          if (mis || tmo) exp_load = 32'h0;
          else if (!wr)   exp_load = rdata;
          if (tmo) exp_terr = 1'b1;
        end
        chk("load_data",   load_data,          exp_load);
        chk("err_timeout", 32'(err_timeout),   32'(exp_terr));
      end
      @(posedge clk); #1;
    end
    exmem_mem_read     = 1'b0;
    exmem_mem_write    = 1'b0;
    exmem_branch_taken = 1'b0;
    dmem_ack           = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic        r, w, b;
    reset = 1'b0;
    exmem_mem_read = 1'b0; exmem_mem_write = 1'b0; exmem_branch_taken = 1'b0;
    exmem_addr = '0; exmem_wdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    exp_load = '0; exp_terr = 1'b0;

    @(negedge clk);
    chk("rst_req",   32'(dmem_req), 32'd0);
    chk("rst_we",    32'(dmem_we),  32'd0);
    chk("rst_addr",  dmem_addr,     32'd0);
    chk("rst_wdata", dmem_wdata,    32'd0);
    chk("rst_load",  load_data,     32'd0);
    chk("rst_mis",   32'(err_misaligned), 32'd0);
    chk("rst_tmo",   32'(err_timeout),    32'd0);
    chk("rst_stall", 32'(stall),    32'd0);
    exmem_branch_taken = 1'b1; #1;
    chk("rst_flush", 32'(flush),    32'd1);
    exmem_branch_taken = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    run_op(1'b1, 1'b0, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 3);
    run_op(1'b0, 1'b1, 1'b0, 32'h204, 32'h12345678, 32'hFFFF0000, 1);
    run_op(1'b1, 1'b0, 1'b0, 32'h103, 32'h0,        32'h55555555, 1);
    run_op(1'b1, 1'b0, 1'b0, 32'h80,  32'h0,        32'hA5A5A5A5, TMO);
    run_op(1'b0, 1'b0, 1'b1, 32'h0,   32'h0,        32'h0,        0);
    run_op(1'b1, 1'b0, 1'b1, 32'h40,  32'h0,        32'h11223344, 2);
    run_op(1'b1, 1'b1, 1'b0, 32'h44,  32'h99887766, 32'h77777777, 2);
    run_op(1'b1, 1'b0, 1'b0, 32'h10,  32'h0,        32'h66666666, 0);
    run_op(1'b1, 1'b0, 1'b0, 32'h20,  32'h0,        32'h0BADCAFE, 1);

    // reset in the second ACCESS cycle of a never-acked load
    exmem_mem_read = 1'b1; exmem_addr = 32'h300; dmem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("pre_rst_req", 32'(dmem_req), 32'd1);
    reset = 1'b0; #1;
    chk("arst_req",   32'(dmem_req), 32'd0);
    chk("arst_addr",  dmem_addr,     32'd0);
    chk("arst_load",  load_data,     32'd0);
    chk("arst_tmo",   32'(err_timeout), 32'd0);
    chk("arst_stall", 32'(stall),    32'd1);
    exmem_mem_read = 1'b0; #1;
    chk("arst_stall_idle", 32'(stall), 32'd0);
    exp_load = '0; exp_terr = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("late_ack_load", load_data,     32'd0);
    chk("late_ack_req",  32'(dmem_req), 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;

    for (int i = 0; i < 40; i++) begin
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      a = $urandom();
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_op(r, w, b, a, $urandom(), $urandom(), int'($urandom_range(0, TMO + 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
